// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch front end: state encoding,
// opcode constants and the default reset vector.
package fetch_pkg;

    localparam int unsigned INSTR_W   = 32;
    localparam int unsigned OPCODE_W  = 6;
    localparam int unsigned IMM_W     = 16;
    localparam int unsigned JTARGET_W = 26;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_WAIT  = 2'd1,
        ST_EXEC  = 2'd2
    } fetch_state_t;

    localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OPCODE_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OPCODE_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OPCODE_W-1:0] OP_BNE   = 6'b000101;
    localparam logic [OPCODE_W-1:0] OP_BGTZ  = 6'b000111;
    localparam logic [OPCODE_W-1:0] OP_J     = 6'b000010;

endpackage

// File: rtl/npc_calc.sv
// Next-PC arithmetic: sequential, taken-branch and (with FETCH_JUMP_EN defined)
// absolute j-type targets. Purely combinational.
module npc_calc
    import fetch_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic [ADDR_W-1:0]  pc,
    input  logic [INSTR_W-1:0] instr,
    input  logic               npc_sel,
    output logic [ADDR_W-1:0]  npc_c
);

    logic [ADDR_W-1:0] pc_plus4;
    logic [ADDR_W-1:0] br_off;

    assign pc_plus4 = pc + ADDR_W'(4);
    // Sign-extended word offset, already shifted left by two.
    assign br_off   = {{(ADDR_W-IMM_W-2){instr[IMM_W-1]}}, instr[IMM_W-1:0], 2'b00};

`ifdef FETCH_JUMP_EN
    logic              is_jump;
    logic [ADDR_W-1:0] jump_tgt;

    assign is_jump  = (instr[INSTR_W-1:INSTR_W-OPCODE_W] == OP_J);
    assign jump_tgt = {pc_plus4[ADDR_W-1:JTARGET_W+2], instr[JTARGET_W-1:0], 2'b00};

    always_comb begin
        npc_c = pc_plus4;
        if (is_jump) begin
            npc_c = jump_tgt;
        end else if (npc_sel) begin
            npc_c = pc_plus4 + br_off;
        end
    end
`else
    logic unused_instr_bits;

    assign unused_instr_bits = ^instr[INSTR_W-1:IMM_W];

    always_comb begin
        npc_c = pc_plus4;
        if (npc_sel) begin
            npc_c = pc_plus4 + br_off;
        end
    end
`endif

endmodule

// File: rtl/fetch_unit.sv
// Sequential fetch front end: FETCH -> WAIT -> EXEC loop over a req/ack
// instruction-memory port. Define FETCH_JUMP_EN to resolve j targets here.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int unsigned ADDR_W   = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic                imem_req,
    output logic [ADDR_W-1:0]   imem_addr,
    input  logic                imem_ack,
    input  logic [INSTR_W-1:0]  imem_rdata,
    output logic                instr_valid,
    output logic [INSTR_W-1:0]  Instruction,
    output logic [OPCODE_W-1:0] Opcode,
    input  logic                retire,
    input  logic                nPC_sel,
    output logic [ADDR_W-1:0]   pc
);

    localparam logic [ADDR_W-1:0] RST_PC = ADDR_W'(RESET_PC) & ~ADDR_W'(3);

    fetch_state_t       state_q, state_d;
    logic [ADDR_W-1:0]  pc_d;
    logic [INSTR_W-1:0] instr_d;
    logic               valid_d;
    logic               req_d;
    logic [ADDR_W-1:0]  npc_c;

    npc_calc #(
        .ADDR_W (ADDR_W)
    ) u_npc_calc (
        .pc      (pc),
        .instr   (Instruction),
        .npc_sel (nPC_sel),
        .npc_c   (npc_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_FETCH;
            pc          <= RST_PC;
            Instruction <= '0;
            instr_valid <= 1'b0;
            imem_req    <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc          <= pc_d;
            Instruction <= instr_d;
            instr_valid <= valid_d;
            imem_req    <= req_d;
        end
    end

    // Next-state and register-input logic; ack/retire only act in their own state.
    always_comb begin
        state_d = state_q;
        pc_d    = pc;
        instr_d = Instruction;
        valid_d = instr_valid;
        unique case (state_q)
            ST_FETCH: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    valid_d = 1'b1;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (retire) begin
                    pc_d    = {npc_c[ADDR_W-1:2], 2'b00};
                    valid_d = 1'b0;
                    state_d = ST_FETCH;
                end
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
        // Request is high whenever the unit is about to be in FETCH or WAIT.
        req_d = (state_d != ST_EXEC);
    end

    assign imem_addr = pc;
    assign Opcode    = Instruction[INSTR_W-1:INSTR_W-OPCODE_W];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a table of fetch/retire records plus
// hand-written sequences for memory wait, stray ack/retire and reset-in-WAIT.
module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] Instruction;
    logic [5:0]  Opcode;
    logic        retire;
    logic        nPC_sel;
    logic [31:0] pc;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef FETCH_JUMP_EN
    localparam logic [31:0] J1_NEXT = 32'h0000_1000;
    localparam logic [31:0] J2_NEXT = 32'h0000_0004;
`else
    localparam logic [31:0] J1_NEXT = 32'h0000_302C;
    localparam logic [31:0] J2_NEXT = 32'h0000_3034;
`endif

    typedef struct {
        logic [31:0] addr;
        logic [31:0] instr;
        int          wait_cyc;
        logic        sel;
        logic [31:0] next;
    } vec_t;

    vec_t vecs[12];

    fetch_unit #(
        .RESET_PC (32'h0000_3000),
        .ADDR_W   (32)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .Instruction (Instruction),
        .Opcode      (Opcode),
        .retire      (retire),
        .nPC_sel     (nPC_sel),
        .pc          (pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Drive one instruction fetch; in_wait means the unit is already in WAIT.
    task automatic do_fetch(input string tag, input logic [31:0] a, input logic [31:0] w,
                            input int wc, input bit in_wait, input bit poke_retire);
        int guard;
        logic [31:0] op;
        guard = 0;
        while (!imem_req && guard < 8) begin
            step();
            guard++;
        end
        chk({tag, " req_seen"}, 32'(imem_req), 32'd1);
        chk({tag, " fetch_addr"}, imem_addr, a);
        if (!in_wait) begin
            step();
            chk({tag, " req_hold"}, 32'(imem_req), 32'd1);
        end
        for (int k = 0; k < wc; k++) begin
            if (poke_retire && k == 1) begin
                retire  = 1'b1;
                nPC_sel = 1'b1;
            end
            step();
            retire  = 1'b0;
            nPC_sel = 1'b0;
            chk({tag, " wait_req"}, 32'(imem_req), 32'd1);
            chk({tag, " wait_valid"}, 32'(instr_valid), 32'd0);
            chk({tag, " wait_pc"}, pc, a);
        end
        imem_ack   = 1'b1;
        imem_rdata = w;
        chk({tag, " valid_at_ack"}, 32'(instr_valid), 32'd0);
        step();
        imem_ack = 1'b0;
        op = 32'(w[31:26]);
        chk({tag, " valid_after_ack"}, 32'(instr_valid), 32'd1);
        chk({tag, " instr"}, Instruction, w);
        chk({tag, " opcode"}, 32'(Opcode), op);
        chk({tag, " req_exec"}, 32'(imem_req), 32'd0);
    endtask

    task automatic do_retire(input string tag, input logic sel, input logic [31:0] nxt);
        retire  = 1'b1;
        nPC_sel = sel;
        step();
        retire  = 1'b0;
        nPC_sel = 1'b0;
        chk({tag, " next_pc"}, pc, nxt);
        chk({tag, " next_addr"}, imem_addr, nxt);
        chk({tag, " req_after_retire"}, 32'(imem_req), 32'd1);
        chk({tag, " valid_cleared"}, 32'(instr_valid), 32'd0);
    endtask

    initial begin
        vecs[0]  = '{32'h0000_3000, 32'h2008_0001, 0, 1'b0, 32'h0000_3004};
        vecs[1]  = '{32'h0000_3004, 32'h8C09_0000, 1, 1'b0, 32'h0000_3008};
        vecs[2]  = '{32'h0000_3008, 32'hAC09_0004, 0, 1'b0, 32'h0000_300C};
        vecs[3]  = '{32'h0000_300C, 32'h0109_5020, 2, 1'b0, 32'h0000_3010};
        vecs[4]  = '{32'h0000_3010, 32'h1109_FFFE, 0, 1'b1, 32'h0000_300C};
        vecs[5]  = '{32'h0000_300C, 32'h1509_0003, 0, 1'b0, 32'h0000_3010};
        vecs[6]  = '{32'h0000_3010, 32'h1109_0003, 0, 1'b1, 32'h0000_3020};
        vecs[7]  = '{32'h0000_3020, 32'h1109_8000, 0, 1'b1, 32'hFFFE_3024};
        vecs[8]  = '{32'hFFFE_3024, 32'h0000_0000, 0, 1'b0, 32'hFFFE_3028};
        vecs[9]  = '{32'hFFFE_3028, 32'h1D09_7FFF, 0, 1'b1, 32'h0000_3028};
        vecs[10] = '{32'h0000_3028, 32'h0800_0400, 0, 1'b0, J1_NEXT};
        vecs[11] = '{J1_NEXT,       32'h0800_0001, 0, 1'b1, J2_NEXT};

        rst_n      = 1'b0;
        imem_ack   = 1'b0;
        imem_rdata = '0;
        retire     = 1'b0;
        nPC_sel    = 1'b0;
        step();
        step();
        chk("rst req", 32'(imem_req), 32'd0);
        chk("rst valid", 32'(instr_valid), 32'd0);
        chk("rst instr", Instruction, 32'd0);
        chk("rst pc", pc, 32'h0000_3000);

        rst_n = 1'b1;
        chk("release req_low", 32'(imem_req), 32'd0);
        step();
        chk("first req", 32'(imem_req), 32'd1);

        for (int i = 0; i < 12; i++) begin
            do_fetch($sformatf("vec%0d", i), vecs[i].addr, vecs[i].instr,
                     vecs[i].wait_cyc, (i == 0), 1'b0);
            do_retire($sformatf("vec%0d", i), vecs[i].sel, vecs[i].next);
        end

        // Slow memory with a stray retire during WAIT.
        do_fetch("slow", J2_NEXT, 32'h2008_ABCD, 4, 1'b0, 1'b1);

        // Stray ack in EXEC must not overwrite the instruction.
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        step();
        imem_ack = 1'b0;
        chk("exec_ack instr", Instruction, 32'h2008_ABCD);
        chk("exec_ack valid", 32'(instr_valid), 32'd1);
        chk("exec_ack pc", pc, J2_NEXT);

        // Ack and retire together in EXEC: only retire acts.
        imem_ack   = 1'b1;
        imem_rdata = 32'h1234_5678;
        retire     = 1'b1;
        nPC_sel    = 1'b0;
        step();
        imem_ack = 1'b0;
        retire   = 1'b0;
        chk("ack_retire pc", pc, J2_NEXT + 32'd4);
        chk("ack_retire instr", Instruction, 32'h2008_ABCD);
        chk("ack_retire valid", 32'(instr_valid), 32'd0);

        // Reset while a read is outstanding; late ack must be ignored.
        step();
        chk("pre_rst req", 32'(imem_req), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("wait_rst req", 32'(imem_req), 32'd0);
        chk("wait_rst valid", 32'(instr_valid), 32'd0);
        chk("wait_rst instr", Instruction, 32'd0);
        chk("wait_rst pc", pc, 32'h0000_3000);
        step();
        rst_n      = 1'b1;
        imem_ack   = 1'b1;
        imem_rdata = 32'hFFFF_FFFF;
        step();
        imem_ack = 1'b0;
        chk("late_ack valid", 32'(instr_valid), 32'd0);
        chk("late_ack req", 32'(imem_req), 32'd1);
        chk("late_ack addr", imem_addr, 32'h0000_3000);
        do_fetch("restart", 32'h0000_3000, 32'h8C0A_0008, 0, 1'b1, 1'b0);
        do_retire("restart", 1'b0, 32'h0000_3004);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
